// File: rtl/frame_word_filler.sv
// frame_word_filler: supplies one telemetry word per buffer read request.
// The word is chosen from the frame read pointer (counter slots or a
// sub-frame fill pattern) or from one of three test patterns. Every slot
// counter is guarded so it advances at most once per visit to its slot.
module frame_word_filler #(
  parameter int WORD_W    = 12,
  parameter int PTR_W     = 10,
  parameter int CNT_W     = 8,
  parameter int UP_SLOT   = 0,
  parameter int DOWN_SLOT = 5,
  parameter int SLOW_SLOT = 297,
  parameter int SUB_W     = 4,
  parameter int FILL_STEP = 11,
  parameter int SLOW_DIV  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bufGetWord,
  input  logic [PTR_W-1:0]  bufRdPointer,
  input  logic [1:0]        mode,
  output logic [WORD_W-1:0] dataWord,
  output logic              wordValid,
  output logic              frameStart
);

  localparam int SLOW_W = WORD_W - 2;
  localparam int RAMP_W = WORD_W - 1;
  localparam int GRP_W  = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;

  localparam logic [PTR_W-1:0] UP_P   = PTR_W'(UP_SLOT);
  localparam logic [PTR_W-1:0] DOWN_P = PTR_W'(DOWN_SLOT);
  localparam logic [PTR_W-1:0] SLOW_P = PTR_W'(SLOW_SLOT);
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(SLOW_DIV - 1);

  // Fill payload: sub-frame index times FILL_STEP, kept modulo 2^CNT_W.
  function automatic logic [CNT_W-1:0] fill_payload(input logic [SUB_W-1:0] sub);
    return CNT_W'(sub) * CNT_W'(FILL_STEP);
  endfunction

  // Checkerboard: odd pointers put a 1 in bit 0, even pointers a 0; MSB is 0.
  function automatic logic [WORD_W-1:0] checker_word(input logic odd);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int i = 0; i < WORD_W - 1; i++) begin
      w[i] = ((i % 2) == 0) ? odd : ~odd;
    end
    return w;
  endfunction

  logic [CNT_W-1:0]  up_cnt_r;
  logic [CNT_W-1:0]  down_cnt_r;
  logic [SLOW_W-1:0] slow_cnt_r;
  logic [GRP_W-1:0]  grp_cnt_r;
  logic              up_arm_r;
  logic              down_arm_r;
  logic              slow_arm_r;
  logic [WORD_W-1:0] word_s;

  // Select the word for the pointer and mode presented in this cycle.
  always_comb begin
    word_s = '0;
    case (mode)
      2'd0: begin
        if (bufRdPointer == UP_P) begin
          word_s[CNT_W+2:3] = up_cnt_r;
          word_s[2:0]       = 3'b001;
        end else if (bufRdPointer == DOWN_P) begin
          word_s[CNT_W+2:3] = down_cnt_r;
          word_s[2:0]       = 3'b001;
        end else if (bufRdPointer == SLOW_P) begin
          word_s[WORD_W-2:1] = slow_cnt_r;
        end else begin
          word_s[CNT_W+2:3] = fill_payload(bufRdPointer[SUB_W-1:0]);
          word_s[2:0]       = 3'b000;
        end
      end
      2'd1: begin
        word_s[2:0] = 3'b010;
      end
      2'd2: begin
        word_s[WORD_W-2:0] = RAMP_W'(bufRdPointer);
      end
      2'd3: begin
        word_s = checker_word(bufRdPointer[0]);
      end
      default: begin
        word_s = '0;
      end
    endcase
  end

  // Serve requests, advance guarded slot counters and drive registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dataWord   <= '0;
      wordValid  <= 1'b0;
      frameStart <= 1'b0;
      up_cnt_r   <= '0;
      down_cnt_r <= '0;
      slow_cnt_r <= '0;
      grp_cnt_r  <= '0;
      up_arm_r   <= 1'b1;
      down_arm_r <= 1'b1;
      slow_arm_r <= 1'b1;
    end else if (bufGetWord) begin
      dataWord   <= word_s;
      wordValid  <= 1'b1;
      frameStart <= (bufRdPointer == '0);

      if (bufRdPointer == UP_P) begin
        if (up_arm_r) begin
          up_cnt_r <= up_cnt_r + CNT_W'(1);
          up_arm_r <= 1'b0;
        end
      end else begin
        up_arm_r <= 1'b1;
      end

      if (bufRdPointer == DOWN_P) begin
        if (down_arm_r) begin
          down_cnt_r <= down_cnt_r - CNT_W'(1);
          down_arm_r <= 1'b0;
        end
      end else begin
        down_arm_r <= 1'b1;
      end

      if (bufRdPointer == SLOW_P) begin
        if (slow_arm_r) begin
          slow_arm_r <= 1'b0;
          grp_cnt_r  <= (grp_cnt_r == GRP_LAST) ? '0 : grp_cnt_r + GRP_W'(1);
          if (grp_cnt_r == '0) begin
            slow_cnt_r <= slow_cnt_r + SLOW_W'(1);
          end
        end
      end else begin
        slow_arm_r <= 1'b1;
      end
    end else begin
      wordValid  <= 1'b0;
      frameStart <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_word_filler.sv
// Self-checking bench for frame_word_filler with default parameters.
// Expected words come from an integer model of the frame rules.
module tb_frame_word_filler;

  logic        clk;
  logic        reset;
  logic        bufGetWord;
  logic [9:0]  bufRdPointer;
  logic [1:0]  mode;
  logic [11:0] dataWord;
  logic        wordValid;
  logic        frameStart;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int m_up, m_down, m_slow, m_grp;
  bit m_uarm, m_darm, m_sarm;
  int last_word;
  int fs_count, val_count;

  frame_word_filler dut (
    .clk(clk), .reset(reset), .bufGetWord(bufGetWord),
    .bufRdPointer(bufRdPointer), .mode(mode),
    .dataWord(dataWord), .wordValid(wordValid), .frameStart(frameStart)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_up = 0; m_down = 0; m_slow = 0; m_grp = 0;
    m_uarm = 1'b1; m_darm = 1'b1; m_sarm = 1'b1;
    last_word = 0;
  endtask

  function automatic int exp_word(input int p, input int m);
    case (m)
      0: begin
        if (p == 0)        return (m_up << 3) | 1;
        else if (p == 5)   return (m_down << 3) | 1;
        else if (p == 297) return m_slow << 1;
        else               return (((p % 16) * 11) % 256) << 3;
      end
      1: return 2;
      2: return p % 2048;
      default: return (p % 2 == 1) ? 'h555 : 'h2AA;
    endcase
  endfunction

  task automatic model_update(input int p);
    if (p == 0) begin
      if (m_uarm) begin m_up = (m_up + 1) % 256; m_uarm = 1'b0; end
    end else m_uarm = 1'b1;
    if (p == 5) begin
      if (m_darm) begin m_down = (m_down + 255) % 256; m_darm = 1'b0; end
    end else m_darm = 1'b1;
    if (p == 297) begin
      if (m_sarm) begin
        if (m_grp == 0) m_slow = (m_slow + 1) % 1024;
        m_grp = (m_grp + 1) % 32;
        m_sarm = 1'b0;
      end
    end else m_sarm = 1'b1;
  endtask

  task automatic req(input int p, input int m);
    int e;
    bufGetWord = 1'b1; bufRdPointer = p[9:0]; mode = m[1:0];
    @(posedge clk); #1;
    e = exp_word(p, m);
    model_update(p);
    chk("word", 32'(dataWord), 32'(e));
    chk("valid", 32'(wordValid), 32'd1);
    chk("frame_start", 32'(frameStart), (p == 0) ? 32'd1 : 32'd0);
    if (wordValid) val_count++;
    if (frameStart) fs_count++;
    last_word = e;
  endtask

  task automatic idle();
    bufGetWord = 1'b0; bufRdPointer = 10'($urandom); mode = 2'($urandom);
    @(posedge clk); #1;
    chk("idle_valid", 32'(wordValid), 32'd0);
    chk("idle_frame_start", 32'(frameStart), 32'd0);
    chk("idle_hold", 32'(dataWord), 32'(last_word));
  endtask

  task automatic do_reset();
    bufGetWord = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_word", 32'(dataWord), 32'd0);
    chk("rst_valid", 32'(wordValid), 32'd0);
    chk("rst_frame_start", 32'(frameStart), 32'd0);
    reset = 1'b1;
    model_reset();
  endtask

  function automatic int rand_other();
    int p;
    p = (($urandom % 2) == 0) ? int'($urandom_range(6, 296)) : int'($urandom_range(298, 1023));
    return p;
  endfunction

  initial begin
    int p, m;
    reset = 1'b0; bufGetWord = 1'b0; bufRdPointer = '0; mode = 2'd0;
    model_reset();
    #3;
    do_reset();

    // first full frame in mode 0
    fs_count = 0; val_count = 0;
    for (int i = 0; i < 1024; i++) begin
      req(i, 0);
      if (i == 0)   chk("sweep1_ptr0", 32'(dataWord), 32'h001);
      if (i == 1)   chk("sweep1_ptr1", 32'(dataWord), 32'h058);
      if (i == 5)   chk("sweep1_ptr5", 32'(dataWord), 32'h001);
      if (i == 297) chk("sweep1_ptr297", 32'(dataWord), 32'h000);
    end
    chk("sweep1_valid_count", 32'(val_count), 32'd1024);
    chk("sweep1_frame_starts", 32'(fs_count), 32'd1);

    // second full frame
    for (int i = 0; i < 1024; i++) begin
      req(i, 0);
      if (i == 0)   chk("sweep2_ptr0", 32'(dataWord), 32'h009);
      if (i == 5)   chk("sweep2_ptr5", 32'(dataWord), 32'h7F9);
      if (i == 297) chk("sweep2_ptr297", 32'(dataWord), 32'h002);
    end
    idle();
    idle();

    // repeated reads of the up slot from a fresh reset
    do_reset();
    req(0, 0); chk("rep_first", 32'(dataWord), 32'h001);
    req(0, 0); chk("rep_second", 32'(dataWord), 32'h009);
    req(0, 0); chk("rep_third", 32'(dataWord), 32'h009);
    req(1, 0);
    req(0, 0); chk("rep_after_other", 32'(dataWord), 32'h009);
    req(1, 0);
    req(0, 0); chk("rep_up_is_2", 32'(dataWord), 32'h011);
    idle();

    // 256 compressed frames: slots plus random filler in random modes
    do_reset();
    for (int f = 1; f <= 257; f++) begin
      req(0, 0);
      if (f == 257) chk("up_wrapped", 32'(dataWord), 32'h001);
      req(5, 0);
      if (f == 257) chk("down_returned", 32'(dataWord), 32'h001);
      for (int k = 0; k < 2; k++) req(rand_other(), int'($urandom_range(0, 3)));
      req(297, 0);
      if (f == 66) chk("slow_frame66", 32'(dataWord), 32'h006);
      if (f == 34) chk("slow_frame34", 32'(dataWord), 32'h004);
      if (f == 33) chk("slow_frame33", 32'(dataWord), 32'h002);
      req(rand_other(), int'($urandom_range(0, 3)));
      if (($urandom % 8) == 0) idle();
    end

    // test modes at 0x155 / 0x154, counters continue underneath
    req(1, 0);
    req(0, 1); chk("mode1_ptr0", 32'(dataWord), 32'h002);
    req(5, 2); chk("mode2_ptr5", 32'(dataWord), 32'h005);
    req('h155, 1); chk("mode1_155", 32'(dataWord), 32'h002);
    req('h155, 2); chk("mode2_155", 32'(dataWord), 32'h155);
    req('h155, 3); chk("mode3_155", 32'(dataWord), 32'h555);
    req('h154, 3); chk("mode3_154", 32'(dataWord), 32'h2AA);
    req(297, 3);
    req(0, 0);
    req(5, 0);
    req(297, 0);
    idle();

    // random back-to-back traffic with idles, slots favoured
    for (int i = 0; i < 3000; i++) begin
      case ($urandom % 6)
        0: p = 0;
        1: p = 5;
        2: p = 297;
        default: p = int'($urandom % 1024);
      endcase
      m = int'($urandom % 4);
      if (($urandom % 5) == 0) idle();
      else req(p, m);
    end

    // reset asserted mid-frame
    for (int i = 380; i <= 400; i++) req(i, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_word", 32'(dataWord), 32'd0);
    chk("async_rst_valid", 32'(wordValid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      bufGetWord = 1'b1; bufRdPointer = 10'd401; mode = 2'd0;
      @(posedge clk); #1;
      chk("in_rst_valid", 32'(wordValid), 32'd0);
      chk("in_rst_word", 32'(dataWord), 32'd0);
    end
    reset = 1'b1;
    model_reset();
    req(0, 0);   chk("post_rst_ptr0", 32'(dataWord), 32'h001);
    req(5, 0);   chk("post_rst_ptr5", 32'(dataWord), 32'h001);
    req(297, 0); chk("post_rst_ptr297", 32'(dataWord), 32'h000);
    req(298, 0);
    req(297, 0); chk("post_rst_slow_stepped", 32'(dataWord), 32'h002);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
